rhs_cmd_sequencer: RTL and testbench

Upstream command source for `rhs_spi_master`. The block continuously sweeps CONVERT commands over the RHS2116 amplifier channels. It inserts one auxiliary slot per sweep, filled either from a host register-command FIFO or with a dummy READ. Each 32-bit command is handed to the SPI master with a one-cycle start pulse, and the block waits for frame completion before enforcing a CS-high gap.

---
 rtl/rhs_cmd_sequencer.sv | 173 +++++++++++++++++
 tb/tb_rhs_cmd_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rhs_cmd_sequencer.sv
// Command sequencer for rhs_spi_master: sweeps CONVERT over NUM_CH channels plus one
// auxiliary slot per sweep, fed from a host FIFO or filled with a dummy READ.
module rhs_cmd_sequencer #(
    parameter int NUM_CH         = 16,
    parameter int FIFO_DEPTH     = 8,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          enable,
    input  logic                          cmd_valid,
    input  logic [31:0]                   cmd_data,
    output logic                          cmd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          spi_start,
    output logic [31:0]                   spi_data,
    input  logic                          spi_done,
    output logic [5:0]                    slot_tag,
    output logic                          sweep_done,
    output logic                          timeout_err,
    input  logic                          err_clr
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW  = $clog2(GAP_CYCLES + 1);

    localparam logic [31:0] DUMMY_WORD = 32'hC0FF_0000;
    localparam logic [5:0]  AUX_SLOT   = 6'(NUM_CH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_e;

    function automatic logic [31:0] convert_word(input logic [5:0] ch);
        return {2'b00, 1'b0, 1'b0, 6'b0, ch, 16'h0000};
    endfunction

    state_e           state_q;
    logic [5:0]       slot_q;
    logic [31:0]      data_q;
    logic             start_q;
    logic             sweep_q;
    logic             terr_q;
    logic [WDW-1:0]   wdog_q;
    logic [GW-1:0]    gap_q;

    logic [31:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             ready_q;

    logic             gap_end;
    logic             load_next;
    logic             aux_load;
    logic             push;
    logic             pop;
    logic             timeout_hit;
    logic             frame_end;
    logic [5:0]       next_slot;
    logic [31:0]      next_word;

    // NOTE: every always_comb output is assigned on every path, so no latches are inferred.
    always_comb begin
        gap_end     = (state_q == S_GAP) && (gap_q == GW'(GAP_CYCLES - 1));
        next_slot   = (slot_q == AUX_SLOT) ? 6'd0 : slot_q + 6'd1;
        load_next   = gap_end && enable;
        aux_load    = load_next && (next_slot == AUX_SLOT);
        // Emptiness is judged on the registered count, i.e. before any same-cycle push.
        pop         = aux_load && (count_q != '0);
        push        = cmd_valid && ready_q;
        count_d     = count_q + CW'(push) - CW'(pop);
        timeout_hit = (state_q == S_WAIT) && !spi_done && (wdog_q == WDW'(TIMEOUT_CYCLES - 1));
        frame_end   = (state_q == S_WAIT) && (spi_done || timeout_hit);
        if (!aux_load)
            next_word = convert_word(next_slot);
        else if (count_q == '0)
            next_word = DUMMY_WORD;
        else
            next_word = mem[rd_ptr_q];
    end

    // NOTE: the FIFO storage has no reset; the pointers and count alone define its contents.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_q] <= cmd_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            ready_q <= (count_d != CW'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            slot_q  <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
            sweep_q <= 1'b0;
            terr_q  <= 1'b0;
            wdog_q  <= '0;
            gap_q   <= '0;
        end else begin
            start_q <= 1'b0;
            sweep_q <= 1'b0;
            if (err_clr)
                terr_q <= 1'b0;
            else if (timeout_hit)
                terr_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        slot_q  <= '0;
                        data_q  <= convert_word(6'd0);
                        start_q <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // The start cycle itself is watchdog count 1.
                    wdog_q  <= WDW'(1);
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (frame_end) begin
                        sweep_q <= (slot_q == AUX_SLOT);
                        gap_q   <= '0;
                        state_q <= S_GAP;
                    end else begin
                        wdog_q <= wdog_q + WDW'(1);
                    end
                end
                S_GAP: begin
                    if (load_next) begin
                        slot_q  <= next_slot;
                        data_q  <= next_word;
                        start_q <= 1'b1;
                        state_q <= S_ISSUE;
                    end else if (gap_end) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready   = ready_q;
    assign fifo_count  = count_q;
    assign spi_start   = start_q;
    assign spi_data    = data_q;
    assign slot_tag    = slot_q;
    assign sweep_done  = sweep_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_rhs_cmd_sequencer.sv
// Directed bench for rhs_cmd_sequencer with a fixed-latency SPI master model.
`timescale 1ns/1ps
module tb_rhs_cmd_sequencer;

    localparam int          LAT   = 40;
    localparam int          TOUT  = 1024;
    localparam logic [31:0] DUMMY = 32'hC0FF_0000;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic        cmd_valid;
    logic [31:0] cmd_data;
    logic        cmd_ready;
    logic [3:0]  fifo_count;
    logic        spi_start;
    logic [31:0] spi_data;
    logic        spi_done;
    logic [5:0]  slot_tag;
    logic        sweep_done;
    logic        timeout_err;
    logic        err_clr;

    int n_cmp = 0;
    int n_err = 0;
    int n_sweep = 0;
    logic master_en = 1'b1;
    longint sweep_t = 0;
    longint aux_done_t = 0;

    logic [31:0] log_data[$];
    logic [5:0]  log_tag[$];
    logic [3:0]  log_cnt[$];
    longint      log_t[$];

    rhs_cmd_sequencer #(
        .NUM_CH(16), .FIFO_DEPTH(8), .GAP_CYCLES(4), .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .cmd_valid(cmd_valid),
        .cmd_data(cmd_data), .cmd_ready(cmd_ready), .fifo_count(fifo_count),
        .spi_start(spi_start), .spi_data(spi_data), .spi_done(spi_done),
        .slot_tag(slot_tag), .sweep_done(sweep_done), .timeout_err(timeout_err),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (spi_start) begin
            log_data.push_back(spi_data);
            log_tag.push_back(slot_tag);
            log_cnt.push_back(fifo_count);
            log_t.push_back($time);
        end
        if (sweep_done) begin
            n_sweep = n_sweep + 1;
            sweep_t = $time;
        end
    end

    // Master model: done pulse LAT cycles after start; abandons the frame on reset.
    initial begin
        int k;
        logic [5:0] t;
        spi_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rstn === 1'b1 && master_en && spi_start) begin
                t = slot_tag;
                for (k = 0; k < LAT && rstn; k++) @(negedge clk);
                if (rstn) begin
                    spi_done = 1'b1;
                    if (t == 6'd16) aux_done_t = $time;
                    @(negedge clk);
                    spi_done = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("comparison %s", tag);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_frames(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && log_data.size() < n; i++) tick();
        check(tag, 64'(log_data.size() >= n), 64'(1));
    endtask

    function automatic logic [31:0] w(input int i);
        return 32'hA100_0000 + 32'(i);
    endfunction

    initial begin
        longint t_seen;
        rstn = 1'b0; enable = 1'b0; cmd_valid = 1'b0; cmd_data = '0; err_clr = 1'b0;
        tick(3);
        check("rst_start", 64'(spi_start), 64'(0));
        check("rst_data", 64'(spi_data), 64'(0));
        check("rst_tag", 64'(slot_tag), 64'(0));
        check("rst_sweep", 64'(sweep_done), 64'(0));
        check("rst_terr", 64'(timeout_err), 64'(0));
        check("rst_ready", 64'(cmd_ready), 64'(1));
        check("rst_count", 64'(fifo_count), 64'(0));
        rstn = 1'b1;
        tick();

        cmd_valid = 1'b1; cmd_data = 32'h8020_00FF;
        tick();
        cmd_valid = 1'b0;
        check("push_count", 64'(fifo_count), 64'(1));

        enable = 1'b1;
        tick();
        check("first_start", 64'(spi_start), 64'(1));
        check("first_tag", 64'(slot_tag), 64'(0));
        check("first_data", 64'(spi_data), 64'(0));

        wait_frames(17, 17 * 45 + 50, "sweep0_frames");
        check("slot5_data", 64'(log_data[5]), 64'(32'h0005_0000));
        check("slot5_tag", 64'(log_tag[5]), 64'(5));
        check("aux0_data", 64'(log_data[16]), 64'(32'h8020_00FF));
        check("aux0_tag", 64'(log_tag[16]), 64'(16));
        check("aux0_count", 64'(log_cnt[16]), 64'(0));
        check("frame_period", 64'(log_t[1] - log_t[0]), 64'(450));
        for (int i = 0; i < 100 && n_sweep < 1; i++) tick();
        check("sweep0_done", 64'(n_sweep), 64'(1));
        check("sweep_done_lat", 64'(sweep_t - aux_done_t), 64'(10));

        wait_frames(35, 18 * 45 + 50, "sweep1_frames");
        check("wrap_tag", 64'(log_tag[17]), 64'(0));
        check("wrap_data", 64'(log_data[17]), 64'(0));
        check("aux1_dummy", 64'(log_data[33]), 64'(DUMMY));
        check("sweep1_done", 64'(n_sweep), 64'(2));

        wait_frames(42, 7 * 45 + 50, "slot7_frames");
        enable = 1'b0;
        check("drop_tag", 64'(log_tag[41]), 64'(7));
        tick(150);
        check("no_more_start", 64'(log_data.size()), 64'(42));

        for (int i = 0; i < 8; i++) begin
            cmd_valid = 1'b1; cmd_data = w(i);
            tick();
        end
        cmd_data = w(8);
        check("full_ready", 64'(cmd_ready), 64'(0));
        check("full_count", 64'(fifo_count), 64'(8));
        tick(5);
        check("held_count", 64'(fifo_count), 64'(8));

        enable = 1'b1;
        tick();
        check("reen_start", 64'(spi_start), 64'(1));
        check("reen_tag", 64'(slot_tag), 64'(0));
        for (int i = 0; i < 1000 && !cmd_ready; i++) tick();
        check("ready_after_pop", 64'(cmd_ready), 64'(1));
        tick();
        cmd_valid = 1'b0;
        check("ninth_count", 64'(fifo_count), 64'(8));
        wait_frames(212, 10 * 17 * 45 + 200, "fifo_frames");
        for (int j = 0; j < 9; j++)
            check($sformatf("aux_order%0d", j), 64'(log_data[42 + 17 * j + 16]), 64'(w(j)));
        check("aux_after_drain", 64'(log_data[211]), 64'(DUMMY));
        check("drained_count", 64'(fifo_count), 64'(0));

        master_en = 1'b0;
        for (int i = 0; i < 1300 && !timeout_err; i++) tick();
        t_seen = $time;
        check("timeout_set", 64'(timeout_err), 64'(1));
        check("timeout_tag", 64'(log_tag[212]), 64'(0));
        check("timeout_lat", 64'((t_seen - 1) - log_t[212]), 64'(TOUT * 10));
        wait_frames(214, 100, "timeout_adv");
        check("adv_tag", 64'(log_tag[213]), 64'(1));
        check("adv_gap", 64'(log_t[213] - log_t[212]), 64'((TOUT + 4) * 10));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
        check("err_clr", 64'(timeout_err), 64'(0));
        for (int i = 0; i < 1100 && ($time - 1) < log_t[213] + (TOUT - 1) * 10; i++) tick();
        err_clr = 1'b1;
        tick();
        check("clr_priority", 64'(timeout_err), 64'(0));
        err_clr = 1'b0;
        master_en = 1'b1;

        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1; cmd_data = w(20 + i);
            tick();
        end
        cmd_valid = 1'b0;
        check("pre_rst_count", 64'(fifo_count), 64'(3));
        wait_frames(216, 3 * 1100, "pre_rst_frames");
        tick(3);
        rstn = 1'b0;
        #1;
        check("arst_start", 64'(spi_start), 64'(0));
        check("arst_data", 64'(spi_data), 64'(0));
        check("arst_tag", 64'(slot_tag), 64'(0));
        check("arst_count", 64'(fifo_count), 64'(0));
        check("arst_ready", 64'(cmd_ready), 64'(1));
        check("arst_terr", 64'(timeout_err), 64'(0));
        enable = 1'b0;
        tick(2);
        rstn = 1'b1;
        tick();
        enable = 1'b1;
        tick();
        check("post_rst_start", 64'(spi_start), 64'(1));
        check("post_rst_tag", 64'(slot_tag), 64'(0));
        check("post_rst_data", 64'(spi_data), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
